// File: rtl/parity_stream_checker.sv
// parity_stream_checker: pipelined per-word parity generate/check with per-frame LRC check.
// Define PARITY_ERR_CNT_EN to add the saturating err_count port and counter.
module parity_stream_checker #(
    parameter int DATA_W = 8,
    parameter int ODD    = 0,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode_check,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_parity,
    input  logic              in_last,
    input  logic [DATA_W-1:0] in_lrc,
    input  logic              err_clr,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_parity,
    output logic              out_last,
    output logic [DATA_W-1:0] out_lrc,
    output logic              word_err,
    output logic              frame_err,
    output logic              err_sticky
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0]  err_count
`endif
);
    typedef enum logic {IDLE, IN_FRAME} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              valid_q, parity_q, last_q, werr_q, ferr_q, sticky_q, sticky_d;
    logic [DATA_W-1:0] data_q, lrc_q;
    logic              p, w_err, f_err, last_beat;
    logic [DATA_W-1:0] lrc;

    // Parity, running LRC including this beat, and frame FSM next state.
    always_comb begin
        p         = ^in_data ^ 1'(ODD);
        lrc       = (state_q == IN_FRAME) ? acc_q ^ in_data : in_data;
        last_beat = in_valid & in_last;
        w_err     = in_valid & mode_check & (in_parity != p);
        f_err     = last_beat & mode_check & (lrc != in_lrc);
        sticky_d  = (sticky_q & ~err_clr) | w_err | f_err;
        state_d   = state_q;
        acc_d     = acc_q;
        if (in_valid) begin
            state_d = in_last ? IDLE : IN_FRAME;
            acc_d   = in_last ? '0 : lrc;
        end
    end

    // State, accumulator and one-cycle output pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            parity_q <= 1'b0;
            last_q   <= 1'b0;
            lrc_q    <= '0;
            werr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            valid_q  <= in_valid;
            data_q   <= in_data;
            parity_q <= mode_check ? in_parity : p;
            last_q   <= last_beat;
            lrc_q    <= last_beat ? lrc : '0;
            werr_q   <= w_err;
            ferr_q   <= f_err;
            sticky_q <= sticky_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_parity = parity_q;
    assign out_last   = last_q;
    assign out_lrc    = lrc_q;
    assign word_err   = werr_q;
    assign frame_err  = ferr_q;
    assign err_sticky = sticky_q;

`ifdef PARITY_ERR_CNT_EN
    localparam logic [CNT_W+1:0] MAX = (CNT_W+2)'({CNT_W{1'b1}});

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W+1:0] sum;

    // Clear applies before this beat's events; a beat may add up to 2, saturating.
    always_comb begin
        sum   = (CNT_W+2)'(err_clr ? '0 : cnt_q) + (CNT_W+2)'(w_err) + (CNT_W+2)'(f_err);
        cnt_d = (sum > MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    // Error event counter register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign err_count = cnt_q;
`endif
endmodule

// File: tb/tb_parity_stream_checker.sv
// tb_parity_stream_checker: directed vectors with hand-computed expectations.
module tb_parity_stream_checker;
    logic       clk = 1'b0;
    logic       rst, mode_check, in_valid, in_parity, in_last, err_clr;
    logic [7:0] in_data, in_lrc;

    logic       ov0, op0, ol0, we0, fe0, es0;
    logic [7:0] od0, olrc0;
    logic       ov1, op1, ol1, we1, fe1, es1;
    logic [7:0] od1, olrc1;
`ifdef PARITY_ERR_CNT_EN
    logic [1:0] ec0;
    logic [7:0] ec1;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Even parity, 2-bit saturating counter.
    parity_stream_checker #(.DATA_W(8), .ODD(0), .CNT_W(2)) dut0 (
        .clk(clk), .rst(rst), .mode_check(mode_check), .in_valid(in_valid),
        .in_data(in_data), .in_parity(in_parity), .in_last(in_last), .in_lrc(in_lrc),
        .err_clr(err_clr), .out_valid(ov0), .out_data(od0), .out_parity(op0),
        .out_last(ol0), .out_lrc(olrc0), .word_err(we0), .frame_err(fe0), .err_sticky(es0)
`ifdef PARITY_ERR_CNT_EN
        , .err_count(ec0)
`endif
    );

    // Odd parity, used for the generate-mode vectors.
    parity_stream_checker #(.DATA_W(8), .ODD(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .mode_check(mode_check), .in_valid(in_valid),
        .in_data(in_data), .in_parity(in_parity), .in_last(in_last), .in_lrc(in_lrc),
        .err_clr(err_clr), .out_valid(ov1), .out_data(od1), .out_parity(op1),
        .out_last(ol1), .out_lrc(olrc1), .word_err(we1), .frame_err(fe1), .err_sticky(es1)
`ifdef PARITY_ERR_CNT_EN
        , .err_count(ec1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs; outputs for it are sampled 1 time unit after the edge.
    task automatic beat(input logic v, input logic [7:0] d, input logic p, input logic l,
                        input logic [7:0] lrc, input logic mc, input logic clr);
        in_valid = v; in_data = d; in_parity = p; in_last = l;
        in_lrc = lrc; mode_check = mc; err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        beat(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        idle();
        check("rst_valid", 32'(ov0), 0);
        check("rst_sticky", 32'(es0), 0);
        check("rst_lrc", 32'(olrc0), 0);
        check("rst_parity", 32'(op1), 0);
`ifdef PARITY_ERR_CNT_EN
        check("rst_count", 32'(ec0), 0);
`endif
        rst = 1'b0;

        // Word parity check, single-word frames.
        beat(1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
        check("w0_valid", 32'(ov0), 1);
        check("w0_werr", 32'(we0), 0);
        check("w0_ferr", 32'(fe0), 0);
        check("w0_lrc", 32'(olrc0), 32'h3C);
        check("w0_data", 32'(od0), 32'h3C);
        check("w0_sticky", 32'(es0), 0);
        beat(1'b1, 8'h1C, 1'b0, 1'b1, 8'h1C, 1'b1, 1'b0);
        check("w1_werr", 32'(we0), 1);
        check("w1_ferr", 32'(fe0), 0);
        check("w1_sticky", 32'(es0), 1);
        check("w1_echo", 32'(op0), 0);
`ifdef PARITY_ERR_CNT_EN
        check("w1_count", 32'(ec0), 1);
`endif
        idle();
        check("gap_valid", 32'(ov0), 0);
        check("gap_werr", 32'(we0), 0);
        check("gap_sticky", 32'(es0), 1);
        beat(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        check("clr_sticky", 32'(es0), 0);
`ifdef PARITY_ERR_CNT_EN
        check("clr_count", 32'(ec0), 0);
`endif

        // Odd-parity generation.
        beat(1'b1, 8'h3C, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        check("gen0_par", 32'(op1), 1);
        check("gen0_werr", 32'(we0), 0);
        beat(1'b1, 8'h3D, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        check("gen1_par", 32'(op1), 0);
        check("gen1_even", 32'(op0), 1);
        beat(1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        check("gen2_par", 32'(op1), 1);
        check("gen_sticky", 32'(es0), 0);

        // Three-beat frame with an idle gap before the last beat.
        beat(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("f0_last", 32'(ol0), 0);
        check("f0_lrc", 32'(olrc0), 0);
        beat(1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        beat(1'b1, 8'h44, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
        check("f0_end_last", 32'(ol0), 1);
        check("f0_end_lrc", 32'(olrc0), 32'h77);
        check("f0_end_ferr", 32'(fe0), 0);
        check("f0_end_sticky", 32'(es0), 0);
        beat(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        beat(1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        beat(1'b1, 8'h44, 1'b0, 1'b1, 8'h76, 1'b1, 1'b0);
        check("f1_ferr", 32'(fe0), 1);
        check("f1_werr", 32'(we0), 0);
        check("f1_sticky", 32'(es0), 1);
`ifdef PARITY_ERR_CNT_EN
        check("f1_count", 32'(ec0), 1);
`endif

        // Reset mid-frame drops the partial frame.
        beat(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        beat(1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        rst = 1'b1;
        beat(1'b1, 8'h44, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
        rst = 1'b0;
        check("r_valid", 32'(ov0), 0);
        check("r_sticky", 32'(es0), 0);
        check("r_ferr", 32'(fe0), 0);
        beat(1'b1, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0);
        check("r_lrc", 32'(olrc0), 32'h5A);
        check("r_frame_ok", 32'(fe0), 0);
        check("r_word_ok", 32'(we0), 0);

        // Saturation with 2-bit counter, then clear plus a double event.
        for (int i = 0; i < 5; i++) begin
            beat(1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
            check("sat_werr", 32'(we0), 1);
`ifdef PARITY_ERR_CNT_EN
            check("sat_count", 32'(ec0), (i < 3) ? i + 1 : 3);
`endif
        end
        beat(1'b1, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
        check("dbl_werr", 32'(we0), 1);
        check("dbl_ferr", 32'(fe0), 1);
        check("dbl_sticky", 32'(es0), 1);
`ifdef PARITY_ERR_CNT_EN
        check("dbl_count", 32'(ec0), 2);
`endif
        idle();
        check("end_ferr", 32'(fe0), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/parity_stream_checker.md
# parity_stream_checker

Parametrised, pipelined parity generator/checker for a valid-qualified data stream, successor to the combinational 8-bit even-parity checker. Per word, it generates or checks a single parity bit with selectable even/odd sense. Per frame, it accumulates a longitudinal redundancy check (LRC, bitwise XOR of all words) and compares it on the last beat. It sits between a data source and the link/serialiser stage, and reports sticky error status plus an error count to control logic.

## Interface
- `DATA_W`, default 8: data word width, 2..64.
- `ODD`, default 0: parity sense. 0 = even (total ones including parity bit is even); 1 = odd.
- `CNT_W`, default 8: error-counter width, 1..32.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `mode_check`  in  1  1 = check supplied parity/LRC; 0 = generate. Sampled per beat.
- `in_valid`  in  1  input beat valid.
- `in_data`  in  DATA_W  input word.
- `in_parity`  in  1  supplied parity bit; used only when `mode_check`=1.
- `in_last`  in  1  last beat of frame; qualified by `in_valid`.
- `in_lrc`  in  DATA_W  expected frame LRC; used only on a check-mode last beat.
- `err_clr`  in  1  clears `err_sticky` and `err_count`.
- `out_valid`  out  1  output beat valid.
- `out_data`  out  DATA_W  registered copy of `in_data`.
- `out_parity`  out  1  generated parity (generate mode) or echo of `in_parity` (check mode).
- `out_last`  out  1  registered `in_last`.
- `out_lrc`  out  DATA_W  accumulated frame LRC; valid only when `out_valid` and `out_last` are both 1, 0 otherwise.
- `word_err`  out  1  parity mismatch on this beat; check mode only.
- `frame_err`  out  1  LRC mismatch on the last beat; check mode only.
- `err_sticky`  out  1  set by any `word_err` or `frame_err`.
- `err_count`  out  CNT_W  error event count, saturating. Present only with `PARITY_ERR_CNT_EN`.

## Operation
- Computed parity: `p = ^in_data ^ ODD`.
- Generate mode: `out_parity` = `p`.
- Check mode: `word_err` = `in_parity != p`.
- Frame FSM has two states.
  - IDLE: a valid beat with `in_last`=0 loads the accumulator `acc` with `in_data` and moves to IN_FRAME. A valid beat with `in_last`=1 is a single-word frame: its LRC is `in_data` and the FSM stays in IDLE.
  - IN_FRAME: each valid beat does `acc ^= in_data`. A beat with `in_last`=1 outputs `acc ^ in_data` as the LRC, clears `acc` and returns to IDLE.
- On the last beat in check mode, `frame_err` = `LRC != in_lrc`. The frame error is independent of `word_err` on the same beat.
- `in_valid`=0 beats are ignored and the state is held. There is no backpressure; the block accepts one beat every cycle.
- Error event: a beat with `word_err` or `frame_err` high. A beat with both high counts as 2 events.
- `err_sticky` is set on any error event and cleared only by `err_clr` or `rst`.
- `err_count` adds the event count per beat and saturates at 2^CNT_W−1.
- `err_clr` together with an error event in the same cycle: the clear applies first, then the new event.
  - Result: `err_sticky`=1 and `err_count` = event count (1 or 2).

## Timing
- Latency is 1 cycle. A beat accepted at edge N appears on the outputs after edge N, with `out_valid`=1 for exactly one cycle per input beat.
- All outputs are registered. `word_err`, `frame_err`, `out_lrc` and `out_last` are 0 whenever `out_valid`=0.
- Reset values are 0 for every output. Reset also clears `acc` and puts the FSM in IDLE.
- `rst` mid-frame drops the partial frame with no `frame_err`. The next valid beat starts a new frame.
- `rst` has priority over `err_clr` and over all beats in the same cycle.
- `err_sticky` and `err_count` update 1 cycle after the erroring input beat, the same edge on which `out_valid` rises.

## Configuration
- `PARITY_ERR_CNT_EN` defined: the `err_count` port and saturating counter are present.
- `PARITY_ERR_CNT_EN` undefined: the `err_count` port and counter are absent. `err_sticky` and all other behaviour are unchanged.

## Test plan
- Setup: DATA_W=8, ODD=0, check mode. Beats 0x3C/p=0 then 0x1C/p=0, both single-word frames with `in_lrc` = `in_data` → `word_err` = 0 then 1, `err_sticky`=1 from the second output cycle, `err_count`=1.
- Setup: ODD=1, generate mode, data 0x3C, 0x3D, 0x00 → `out_parity` = 1, 0, 1, each one cycle after input.
- Frame check: 3-beat frame 0x11, 0x22, 0x44 with `in_lrc`=0x77 → `frame_err`=0, `out_lrc`=0x77 on the last beat. Repeat with `in_lrc`=0x76 → `frame_err`=1, `err_count` += 1.
- Reset and gaps: reset after 2 beats of a frame, then a 1-beat frame 0x5A with `in_lrc`=0x5A → no `frame_err`, `out_lrc`=0x5A, no residue from the aborted frame. Idle cycles between beats do not change `acc`.
- Counter saturation: CNT_W=2 with 5 bad beats → `err_count` sticks at 3. `err_clr` in the same cycle as a beat carrying both `word_err` and `frame_err` → `err_count`=2, `err_sticky`=1.
- Without `PARITY_ERR_CNT_EN`: repeat the first scenario → identical `word_err`/`err_sticky` behaviour, and the build has no `err_count` port.
